l2_writeback_buffer: RTL

- Drain-side counterpart to the L2 data array: captures dirty 256-bit lines that the L2 controller reads out of the array on eviction.
- Queues them and writes them to physical memory over the pmem write handshake.
- Provides a snoop port so an L2 miss to a line still queued here returns the buffered data, not stale memory.
- Sits between the L2 controller/array and the physical memory arbiter.

---
 rtl/l2_types.sv | 20 ++
 rtl/l2_wb_match.sv | 36 +++
 rtl/l2_writeback_buffer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/l2_types.sv
// Shared types and sizing for the L2 writeback buffer.
// Sizing constants, drain FSM state encoding and the queued-line record.
package l2_types;

    localparam int WB_WIDTH  = 256;
    localparam int WB_ADDR_W = 32;
    localparam int WB_DEPTH  = 4;
    localparam int WB_OFF    = 5;

    typedef enum logic {
        WB_IDLE,
        WB_WRITE
    } wb_state_t;

    typedef struct packed {
        logic [WB_ADDR_W-1:WB_OFF] line;
        logic [WB_WIDTH-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/l2_wb_match.sv
// Youngest-first line-address matcher over the writeback queue entries.
// Latency: purely combinational.
// Backpressure: none; it only observes the queue state.
module l2_wb_match
    import l2_types::*;
#(
    parameter int DEPTH  = WB_DEPTH,
    parameter int LINE_W = WB_ADDR_W - WB_OFF,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic [LINE_W-1:0] ent_line [DEPTH],
    input  logic [DEPTH-1:0]  ent_vld,
    input  logic [PTR_W-1:0]  tail,
    input  logic [LINE_W-1:0] lookup_line,
    output logic              hit,
    output logic [PTR_W-1:0]  sel
);

    logic [PTR_W-1:0] idx;

    // Walk from the oldest slot (tail) towards the youngest (tail-1);
    // the last match seen is the youngest one.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = tail + PTR_W'(k);
            if (ent_vld[idx] && (ent_line[idx] == lookup_line)) begin
                hit = 1'b1;
                sel = idx;
            end
        end
    end

endmodule

// File: rtl/l2_writeback_buffer.sv
// Queues evicted dirty L2 lines and drains them to pmem; snoop port serves queued data.
// Latency: accept edge, then IDLE->WRITE edge (2 cycles); one bubble between writes.
// Backpressure: wb_ready low while full; pmem_write held until pmem_resp.
module l2_writeback_buffer
    import l2_types::*;
#(
    parameter int WIDTH  = WB_WIDTH,
    parameter int DEPTH  = WB_DEPTH,
    parameter int ADDR_W = WB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [WIDTH-1:0]  wb_data,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              lookup_hit,
    output logic [WIDTH-1:0]  lookup_data,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [WIDTH-1:0]  pmem_wdata,
    input  logic              pmem_resp,
    output logic              empty
);

    localparam int OFF    = $clog2(WIDTH / 8);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int LINE_W = ADDR_W - OFF;

    logic [LINE_W-1:0] ent_line [DEPTH];
    logic [WIDTH-1:0]  ent_data [DEPTH];
    logic [DEPTH-1:0]  ent_vld;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    wb_state_t         state;

    logic              push;
    logic              pop;
    logic              match_hit;
    logic [PTR_W-1:0]  match_sel;
    logic              unused_offset_bits;

    assign wb_ready     = (count != CNT_W'(DEPTH));
    assign empty        = (count == '0);
    assign push         = wb_valid && wb_ready;
    assign pop          = (state == WB_WRITE) && pmem_resp;
    assign pmem_address = {ent_line[head], {OFF{1'b0}}};
    assign pmem_wdata   = ent_data[head];
    assign unused_offset_bits = ^{wb_addr[OFF-1:0], lookup_addr[OFF-1:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_line[i] <= '0;
                ent_data[i] <= '0;
            end
            ent_vld <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
        end else begin
            // Slot at head is only popped when non-empty and tail only written when
            // not full, so the two valid-bit updates never target the same slot.
            if (pop) begin
                ent_vld[head] <= 1'b0;
                head          <= head + PTR_W'(1);
            end
            if (push) begin
                ent_line[tail] <= wb_addr[ADDR_W-1:OFF];
                ent_data[tail] <= wb_data;
                ent_vld[tail]  <= 1'b1;
                tail           <= tail + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= WB_IDLE;
            pmem_write <= 1'b0;
        end else begin
            case (state)
                WB_IDLE: begin
                    if (count != '0) begin
                        state      <= WB_WRITE;
                        pmem_write <= 1'b1;
                    end
                end
                WB_WRITE: begin
                    if (pmem_resp) begin
                        state      <= WB_IDLE;
                        pmem_write <= 1'b0;
                    end
                end
                default: begin
                    state      <= WB_IDLE;
                    pmem_write <= 1'b0;
                end
            endcase
        end
    end

    l2_wb_match #(
        .DEPTH  (DEPTH),
        .LINE_W (LINE_W)
    ) u_match (
        .ent_line    (ent_line),
        .ent_vld     (ent_vld),
        .tail        (tail),
        .lookup_line (lookup_addr[ADDR_W-1:OFF]),
        .hit         (match_hit),
        .sel         (match_sel)
    );

    assign lookup_hit  = match_hit;
    assign lookup_data = match_hit ? ent_data[match_sel] : '0;

endmodule
